level_slew: RTL



---
 rtl/level_slew.sv | 105 ++++++++++
 1 files changed

// File: rtl/level_slew.sv
// Slew-rate limiter: ramps an internal level toward the encoder target at STEP LSBs per
// TICK_DIV clocks and publishes it on PWM frame boundaries. Optional LEVEL_GAMMA_EN adds a gamma stage.
module level_slew #(
    parameter int WIDTH    = 8,
    parameter int STEP     = 1,
    parameter int TICK_DIV = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] target,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] level,
    output logic             settled
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [WIDTH:0] STEP_W = (WIDTH + 1)'(STEP);

    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

    state_t           state;
    logic             tick;
    logic [PW-1:0]    prescaler_q, prescaler_d;
    logic [WIDTH-1:0] current_q, current_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             settled_q, settled_d;
    logic [WIDTH:0]   sum, diff;

    assign tick = (prescaler_q == TICK_LAST);

    always_comb begin
        state = IDLE;
        if (current_q < target) begin
            state = UP;
        end else if (current_q > target) begin
            state = DOWN;
        end
    end

    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    always_comb begin
        prescaler_d = tick ? '0 : prescaler_q + 1'b1;
        sum         = {1'b0, current_q} + STEP_W;
        diff        = {1'b0, current_q} - STEP_W;
        current_d   = current_q;
        if (tick) begin
            case (state)
                UP:      current_d = (sum >= {1'b0, target}) ? target : sum[WIDTH-1:0];
                // A borrow out of the MSB means the step would go below zero.
                DOWN:    current_d = (diff[WIDTH] || diff <= {1'b0, target}) ? target : diff[WIDTH-1:0];
                default: current_d = current_q;
            endcase
        end
        q_d = frame_sync ? current_q : q_q;
    end

`ifdef LEVEL_GAMMA_EN
    logic [WIDTH-1:0]   level_q, gamma_d;
    logic [WIDTH-1:0]   gsrc_q;
    logic [2*WIDTH-1:0] q_ext, prod;

    always_comb begin
        q_ext   = {{WIDTH{1'b0}}, q_q};
        prod    = (q_ext + 1'b1) * q_ext;
        gamma_d = WIDTH'(prod >> WIDTH);
    end

    // gsrc_q remembers which q the gamma output was computed from.
    assign settled_d = (state == IDLE) && (q_q == current_q) && (gsrc_q == q_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= '0;
            gsrc_q  <= '0;
        end else begin
            level_q <= gamma_d;
            gsrc_q  <= q_q;
        end
    end

    assign level = level_q;
`else
    assign settled_d = (state == IDLE) && (q_q == current_q);
    assign level     = q_q;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler_q <= '0;
            current_q   <= '0;
            q_q         <= '0;
            settled_q   <= 1'b1;
        end else begin
            prescaler_q <= prescaler_d;
            current_q   <= current_d;
            q_q         <= q_d;
            settled_q   <= settled_d;
        end
    end

    assign settled = settled_q;

endmodule
